rv32_pipe_ctrl: RTL

RV32_PIPE_CTRL -- requirements
Module: rv32_pipe_ctrl

---
 rtl/rv32_pkg.sv | 21 ++
 rtl/rv32_sat_cnt.sv | 25 ++
 rtl/rv32_pipe_ctrl.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/rv32_pkg.sv
// rv32_pkg -- shared definitions for the RV32 core control slice.
//
// Contents:
//   pctl_state_t : pipeline-control FSM state encoding (3 bits, exposed
//                  directly on rv32_pipe_ctrl.state_out for debug).
//   NOP_IW       : canonical NOP (addi x0, x0, 0) that the datapath loads
//                  into IF/ID or ID/EX when the matching flush is asserted.
package rv32_pkg;

    localparam logic [31:0] NOP_IW = 32'h0000_0013;

    typedef enum logic [2:0] {
        PCTL_RUN      = 3'd0,
        PCTL_HAZ      = 3'd1,
        PCTL_MEM_WAIT = 3'd2,
        PCTL_REDIRECT = 3'd3,
        PCTL_HALT     = 3'd4,
        PCTL_ERR      = 3'd5
    } pctl_state_t;

endpackage

// File: rtl/rv32_sat_cnt.sv
// rv32_sat_cnt -- enable-driven up-counter that sticks at all-ones.
//
// Ports:
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset, clears count
//   en      : increment request for this cycle
//   count   : current value (W bits), never wraps
module rv32_sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         en,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (en && !(&count)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/rv32_pipe_ctrl.sv
// rv32_pipe_ctrl -- 5-stage pipeline stall/flush/redirect controller.
//
// Ports:
//   clk, reset_n            : rising-edge clock, async active-low reset
//   dmem_busy               : MEM access pending, freezes the whole pipe
//   halt_req / resume       : enter HALT (EBREAK/ECALL retiring) / leave HALT
//   jump_req / jump_addr    : ID resolved a taken control transfer
//   hazard_req              : ID load-use hazard, bubble into EX
//   if_en..wb_en            : pipeline register enables
//   if_flush / id_flush     : load NOP_IW into IF/ID / ID/EX
//   pc_redirect / redirect_addr : PC load strobe and target (0 when idle)
//   halted / err            : in HALT / sticky memory-timeout
//   stall_cycles            : cycles with IF frozen outside HALT/ERR
//   flush_count             : cycles with any flush asserted
//   state_out               : current FSM state (pctl_state_t encoding)
//
// Handshake notes: all request inputs are level-sampled every cycle; there
// is no ready/acknowledge. The outputs are combinational from the
// registered state plus the current inputs, so a request is acted on in the
// cycle it is presented. Per-cycle priority:
//   ERR > dmem_busy > HALT/halt_req > (REDIRECT squash) > jump_req > hazard_req
// MAX_MEM_WAIT must be at least 1.
module rv32_pipe_ctrl
    import rv32_pkg::*;
#(
    parameter int MAX_MEM_WAIT = 15,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             dmem_busy,
    input  logic             halt_req,
    input  logic             resume,
    input  logic             jump_req,
    input  logic [31:0]      jump_addr,
    input  logic             hazard_req,
    output logic             if_en,
    output logic             id_en,
    output logic             ex_en,
    output logic             mem_en,
    output logic             wb_en,
    output logic             if_flush,
    output logic             id_flush,
    output logic             pc_redirect,
    output logic [31:0]      redirect_addr,
    output logic             halted,
    output logic             err,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [15:0]      flush_count,
    output logic [2:0]       state_out
);

    localparam int WC_W = $clog2(MAX_MEM_WAIT + 1);

    pctl_state_t     state, state_nxt;
    logic [WC_W-1:0] wait_cnt, wait_cnt_nxt;

    // Ungated control decisions; the ports below force them low in reset.
    logic if_en_c, id_en_c, ex_en_c, mem_en_c, wb_en_c;
    logic if_flush_c, id_flush_c, pc_redirect_c;

    logic stall_inc, flush_inc;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= PCTL_RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state and control outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt     = PCTL_RUN;
        wait_cnt_nxt  = '0;
        if_en_c       = 1'b1;
        id_en_c       = 1'b1;
        ex_en_c       = 1'b1;
        mem_en_c      = 1'b1;
        wb_en_c       = 1'b1;
        if_flush_c    = 1'b0;
        id_flush_c    = 1'b0;
        pc_redirect_c = 1'b0;

        if (state == PCTL_ERR) begin
            // Terminal until reset.
            {if_en_c, id_en_c, ex_en_c, mem_en_c, wb_en_c} = 5'b0;
            state_nxt = PCTL_ERR;
        end else if (dmem_busy) begin
            {if_en_c, id_en_c, ex_en_c, mem_en_c, wb_en_c} = 5'b0;
            wait_cnt_nxt = wait_cnt + 1'b1;
            // This busy cycle is the MAX_MEM_WAIT-th in a row: give up.
            if (32'(wait_cnt) + 32'd1 >= 32'(MAX_MEM_WAIT)) begin
                state_nxt = PCTL_ERR;
            end else begin
                state_nxt = PCTL_MEM_WAIT;
            end
        end else if (state == PCTL_HALT) begin
            {if_en_c, id_en_c, ex_en_c, mem_en_c, wb_en_c} = 5'b0;
            state_nxt = resume ? PCTL_RUN : PCTL_HALT;
        end else if (halt_req) begin
            // Freeze on the retiring EBREAK/ECALL cycle so nothing younger
            // advances behind it before HALT takes over.
            {if_en_c, id_en_c, ex_en_c, mem_en_c, wb_en_c} = 5'b0;
            state_nxt = PCTL_HALT;
        end else if (state == PCTL_REDIRECT) begin
            // The ID slot holds the squashed wrong-path instruction, so its
            // jump/hazard requests are meaningless here.
            state_nxt = PCTL_RUN;
        end else if (jump_req) begin
            pc_redirect_c = 1'b1;
            if_flush_c    = 1'b1;
            state_nxt     = PCTL_REDIRECT;
        end else if (hazard_req) begin
            // Hold PC and IF/ID, push a bubble into EX, let older drain.
            if_en_c    = 1'b0;
            id_en_c    = 1'b0;
            id_flush_c = 1'b1;
            state_nxt  = PCTL_HAZ;
        end
    end

    assign if_en         = if_en_c & reset_n;
    assign id_en         = id_en_c & reset_n;
    assign ex_en         = ex_en_c & reset_n;
    assign mem_en        = mem_en_c & reset_n;
    assign wb_en         = wb_en_c & reset_n;
    assign if_flush      = if_flush_c & reset_n;
    assign id_flush      = id_flush_c & reset_n;
    assign pc_redirect   = pc_redirect_c & reset_n;
    assign redirect_addr = pc_redirect ? jump_addr : 32'h0;
    assign halted        = (state == PCTL_HALT) & reset_n;
    assign err           = (state == PCTL_ERR) & reset_n;
    assign state_out     = state;

    // ------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------
    assign stall_inc = !if_en && (state != PCTL_HALT) && (state != PCTL_ERR);
    assign flush_inc = if_flush | id_flush;

    rv32_sat_cnt #(.W(CNT_W)) u_stall_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (stall_inc),
        .count   (stall_cycles)
    );

    rv32_sat_cnt #(.W(16)) u_flush_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (flush_inc),
        .count   (flush_count)
    );

endmodule
